cmp_debounce_fsm: RTL and testbench

//   Downstream consumer of the W-bit magnitude comparator's g/e/l flags.

---
 rtl/cmp_debounce_fsm_if.sv | 27 ++
 rtl/cmp_debounce_fsm.sv | 118 +++++++++++
 tb/tb_cmp_debounce_fsm.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cmp_debounce_fsm_if.sv
// Bus between the comparator flag source and the debounce FSM:
// per-sample g/e/l flags in, stable decision and status out.
interface cmp_debounce_fsm_if #(
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             g;
    logic             e;
    logic             l;
    logic             hi;
    logic             mid;
    logic             lo;
    logic             known;
    logic             chg;
    logic             illegal;
    logic [CNT_W-1:0] run_cnt;

    modport master (
        output in_valid, g, e, l,
        input  hi, mid, lo, known, chg, illegal, run_cnt
    );

    modport slave (
        input  in_valid, g, e, l,
        output hi, mid, lo, known, chg, illegal, run_cnt
    );
endinterface

// File: rtl/cmp_debounce_fsm.sv
// Debounces the comparator's per-sample g/e/l relation into a stable HI/MID/LO
// decision; a new relation is accepted after HOLD consecutive agreeing valid samples.
module cmp_debounce_fsm #(
    parameter int HOLD  = 3,
    parameter int CNT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    cmp_debounce_fsm_if.slave         bus
);
    // S_UNK doubles as "no candidate" for cand and as "illegal" for the sample class.
    typedef enum logic [1:0] {
        S_UNK = 2'd0,
        S_HI  = 2'd1,
        S_MID = 2'd2,
        S_LO  = 2'd3
    } st_e;

    localparam logic [CNT_W:0]   HOLD_W  = (CNT_W+1)'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic st_e classify(input logic g_f, input logic e_f, input logic l_f);
        st_e c;
        case ({g_f, e_f, l_f})
            3'b100:  c = S_HI;
            3'b010:  c = S_MID;
            3'b001:  c = S_LO;
            default: c = S_UNK;
        endcase
        return c;
    endfunction

    st_e              state_q, state_d;
    st_e              cand_q,  cand_d;
    st_e              cls_s;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W:0]   inc_s;
    logic             illegal_q, illegal_d;
    logic             chg_q,     chg_d;
    logic             hi_q, mid_q, lo_q, known_q;

    // Next-state, run counter and sticky illegal flag.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        chg_d     = 1'b0;
        cls_s     = classify(bus.g, bus.e, bus.l);
        inc_s     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        if (bus.in_valid) begin
            if (cls_s == S_UNK) begin
                illegal_d = 1'b1;
                cnt_d     = {CNT_W{1'b0}};
                cand_d    = S_UNK;
            end else if (cls_s == state_q) begin
                cnt_d  = {CNT_W{1'b0}};
                cand_d = S_UNK;
            end else if (cls_s == cand_q) begin
                if (inc_s == HOLD_W) begin
                    state_d = cls_s;
                    chg_d   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    cand_d  = S_UNK;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = inc_s[CNT_W-1:0];
                end
            end else begin
                if (HOLD == 1) begin
                    state_d = cls_s;
                    chg_d   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    cand_d  = S_UNK;
                end else begin
                    cand_d = cls_s;
                    cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            chg_d = 1'b0;
        end
    end

    // State, counter and registered output decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_UNK;
            cand_q    <= S_UNK;
            cnt_q     <= {CNT_W{1'b0}};
            illegal_q <= 1'b0;
            chg_q     <= 1'b0;
            hi_q      <= 1'b0;
            mid_q     <= 1'b0;
            lo_q      <= 1'b0;
            known_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            chg_q     <= chg_d;
            hi_q      <= (state_d == S_HI);
            mid_q     <= (state_d == S_MID);
            lo_q      <= (state_d == S_LO);
            known_q   <= (state_d != S_UNK);
        end
    end

    assign bus.hi      = hi_q;
    assign bus.mid     = mid_q;
    assign bus.lo      = lo_q;
    assign bus.known   = known_q;
    assign bus.chg     = chg_q;
    assign bus.illegal = illegal_q;
    assign bus.run_cnt = cnt_q;
endmodule

// File: tb/tb_cmp_debounce_fsm.sv
// Directed bench for cmp_debounce_fsm: a HOLD=3 instance for the main scenarios
// and a HOLD=1 instance sharing the same stimulus for the immediate-accept case.
module tb_cmp_debounce_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    cmp_debounce_fsm_if #(.CNT_W(4)) bus0 ();
    cmp_debounce_fsm_if #(.CNT_W(4)) bus1 ();

    cmp_debounce_fsm #(.HOLD(3), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    cmp_debounce_fsm #(.HOLD(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %b want %b", tag, obs[9:0], exp[9:0]);
    endtask

    // Packed view: {hi, mid, lo, known, chg, illegal, run_cnt[3:0]}
    task automatic exp0(input string tag, input logic h, m, o, k, c, il, input logic [3:0] r);
        chk(tag, {22'd0, bus0.hi, bus0.mid, bus0.lo, bus0.known, bus0.chg, bus0.illegal, bus0.run_cnt},
                 {22'd0, h, m, o, k, c, il, r});
    endtask

    task automatic exp1(input string tag, input logic h, m, o, k, c, il, input logic [3:0] r);
        chk(tag, {22'd0, bus1.hi, bus1.mid, bus1.lo, bus1.known, bus1.chg, bus1.illegal, bus1.run_cnt},
                 {22'd0, h, m, o, k, c, il, r});
    endtask

    task automatic step(input logic v, input logic gg, input logic ee, input logic ll, input logic r);
        @(negedge clk);
        rst           = r;
        bus0.in_valid = v;  bus0.g = gg; bus0.e = ee; bus0.l = ll;
        bus1.in_valid = v;  bus1.g = gg; bus1.e = ee; bus1.l = ll;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.g = 1'b0; bus0.e = 1'b0; bus0.l = 1'b0;
        bus1.in_valid = 1'b0; bus1.g = 1'b0; bus1.e = 1'b0; bus1.l = 1'b0;

        // reset and idle
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp0("rst",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        exp1("rst_h1",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp0("idle",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // UNK -> HI after three g samples
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("g1",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("g2",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("g3_hi",    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp0("hi_chg0",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // HI: l,l,g,l,l,l -> LO
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp0("l1",       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp0("l2",       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("g_clr",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp0("l1b",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp0("l2b",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp0("l3_lo",    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp0("lo_chg0",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // LO: e, l (clears), e, gap x4, e, e -> MID
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp0("e_pre",    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp0("l_clr",    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp0("e1",       1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp0("gap",      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp0("e2",       1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp0("e3_mid",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // illegal combinations, sticky through later legal transitions
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("g_run",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp0("ill_ge",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp0("ill_none", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("ill_g1",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("ill_g2",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("ill_hi",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);

        // reset mid-run discards candidate; reset beats in_valid
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp0("rst2",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("pre_rst",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        exp0("rst_mid",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        exp1("h1_rst",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("post_g1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        exp1("h1_g_hi",  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp0("post_g2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        exp1("h1_g_hold",1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp0("post_l",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        exp1("h1_l_lo",  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        exp1("h1_ill",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
